// File: rtl/rf_wb_queue_pkg.sv
// rf_wb_queue_pkg: shared widths, depth and entry type for the write-back queue
package rf_wb_queue_pkg;
   localparam int RF_SEL_W    = 3;
   localparam int RF_DATA_W   = 16;
   localparam int RF_NUM_REGS = 8;
   localparam int WBQ_DEPTH   = 4;
   localparam int WBQ_CNT_W   = $clog2(WBQ_DEPTH + 1);
   typedef struct packed {
      logic [RF_SEL_W-1:0]  sel;
      logic [RF_DATA_W-1:0] data;
   } wbq_entry_t;
endpackage

// File: rtl/wbq_fifo4.sv
// wbq_fifo4: 4-entry in-order FIFO exposing entries oldest-first with per-entry valids
module wbq_fifo4
   import rf_wb_queue_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic                 pop,
   input  wbq_entry_t           wdata,
   output logic [WBQ_CNT_W-1:0] count,
   output wbq_entry_t           ents [WBQ_DEPTH],
   output logic [WBQ_DEPTH-1:0] vld
);
   wbq_entry_t mem [WBQ_DEPTH];
   logic [1:0] rd_ptr, wr_ptr;
   logic do_push, do_pop;
   assign do_push = push && (count < WBQ_CNT_W'(WBQ_DEPTH));
   assign do_pop  = pop && (count != '0);
   // storage needs no reset: visibility is governed by count alone
   always_ff @(posedge clk)
      if (do_push && !rst) mem[wr_ptr] <= wdata;
   // pointers wrap naturally at 2 bits; simultaneous push/pop keeps count
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 2'd1;
         if (do_pop) rd_ptr <= rd_ptr + 2'd1;
         count <= count + WBQ_CNT_W'(do_push) - WBQ_CNT_W'(do_pop);
      end
   end
   // rotate storage so slot 0 is the head and higher slots are younger
   always_comb begin
      for (int k = 0; k < WBQ_DEPTH; k++) begin
         ents[k] = mem[rd_ptr + 2'(k)];
         vld[k]  = WBQ_CNT_W'(k) < count;
      end
   end
endmodule

// File: rtl/rf_wb_queue.sv
// rf_wb_queue: register-file write-back queue with pending mask, X-select error flag
// and optional read forwarding enabled by the RF_WB_FWD_EN macro
module rf_wb_queue
   import rf_wb_queue_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   inValid,
   output logic                   inReady,
   input  logic [RF_SEL_W-1:0]    inRegSel,
   input  logic [RF_DATA_W-1:0]   inData,
   input  logic                   wbStall,
   output logic [RF_SEL_W-1:0]    writeRegSel,
   output logic [RF_DATA_W-1:0]   writeData,
   output logic                   writeEn,
   output logic [RF_NUM_REGS-1:0] pending,
   input  logic [RF_SEL_W-1:0]    readReg1Sel,
   input  logic [RF_SEL_W-1:0]    readReg2Sel,
   output logic                   fwdHit1,
   output logic                   fwdHit2,
   output logic [RF_DATA_W-1:0]   fwdData1,
   output logic [RF_DATA_W-1:0]   fwdData2,
   output logic                   err
);
   logic [WBQ_CNT_W-1:0] count;
   wbq_entry_t ents [WBQ_DEPTH];
   logic [WBQ_DEPTH-1:0] vld;
   wbq_entry_t in_ent;
   logic push;
   assign err         = inValid && $isunknown(inRegSel);
   assign inReady     = (count < WBQ_CNT_W'(WBQ_DEPTH)) && !rst;
   assign push        = inValid && inReady && !err;
   assign writeEn     = (count != '0) && !wbStall;
   assign writeRegSel = vld[0] ? ents[0].sel : '0;
   assign writeData   = vld[0] ? ents[0].data : '0;
   assign in_ent      = '{sel: inRegSel, data: inData};
   wbq_fifo4 u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (writeEn),
      .wdata (in_ent),
      .count (count),
      .ents  (ents),
      .vld   (vld)
   );
   // pending: one-hot of every live entry's destination register
   always_comb begin
      pending = '0;
      for (int k = 0; k < WBQ_DEPTH; k++)
         pending |= vld[k] ? RF_NUM_REGS'(1) << ents[k].sel : '0;
   end
`ifdef RF_WB_FWD_EN
   // scan oldest to youngest so the youngest matching entry's data wins
   always_comb begin
      fwdHit1  = 1'b0;
      fwdHit2  = 1'b0;
      fwdData1 = '0;
      fwdData2 = '0;
      for (int k = 0; k < WBQ_DEPTH; k++) begin
         if (vld[k] && ents[k].sel == readReg1Sel) begin
            fwdHit1  = 1'b1;
            fwdData1 = ents[k].data;
         end
         if (vld[k] && ents[k].sel == readReg2Sel) begin
            fwdHit2  = 1'b1;
            fwdData2 = ents[k].data;
         end
      end
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{readReg1Sel, readReg2Sel};
   assign fwdHit1    = 1'b0;
   assign fwdHit2    = 1'b0;
   assign fwdData1   = '0;
   assign fwdData2   = '0;
`endif
endmodule

// File: tb/tb_rf_wb_queue.sv
// tb_rf_wb_queue: table-driven check of rf_wb_queue plus forwarding/reset/error sequences
module tb_rf_wb_queue;
   logic clk = 1'b0, rst = 1'b1;
   logic in_valid = 1'b0, wb_stall = 1'b0;
   logic in_ready, write_en, fwd_hit1, fwd_hit2, err;
   logic [2:0] in_sel = '0, write_sel, rd1 = '0, rd2 = '0;
   logic [15:0] in_data = '0, write_data, fwd_data1, fwd_data2;
   logic [7:0] pending;
   int n_cmp = 0, n_fail = 0;

   always #5 clk = ~clk;

   rf_wb_queue dut (
      .clk         (clk),
      .rst         (rst),
      .inValid     (in_valid),
      .inReady     (in_ready),
      .inRegSel    (in_sel),
      .inData      (in_data),
      .wbStall     (wb_stall),
      .writeRegSel (write_sel),
      .writeData   (write_data),
      .writeEn     (write_en),
      .pending     (pending),
      .readReg1Sel (rd1),
      .readReg2Sel (rd2),
      .fwdHit1     (fwd_hit1),
      .fwdHit2     (fwd_hit2),
      .fwdData1    (fwd_data1),
      .fwdData2    (fwd_data2),
      .err         (err)
   );

   typedef struct {
      logic        v;
      logic [2:0]  sel;
      logic [15:0] data;
      logic        stall;
      logic        rdy;
      logic        we;
      logic [2:0]  wsel;
      logic [15:0] wdata;
      logic [7:0]  pend;
   } vec_t;

   vec_t vt [24];

`ifdef RF_WB_FWD_EN
   localparam logic FWD = 1'b1;
`else
   localparam logic FWD = 1'b0;
`endif

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [2:0] sel, input logic [15:0] data, input logic stall);
      in_valid = v;
      in_sel   = sel;
      in_data  = data;
      wb_stall = stall;
   endtask

   initial begin
      logic [2:0] xsel;
      logic exp_err;
      //        v   sel    data       stall rdy we  wsel   wdata      pend
      vt[0]  = '{'0, 3'd0, 16'h0000, '0,   '1, '0, 3'd0, 16'h0000, 8'h00};
      vt[1]  = '{'1, 3'd3, 16'h1234, '0,   '1, '0, 3'd0, 16'h0000, 8'h00};
      vt[2]  = '{'0, 3'd0, 16'h0000, '0,   '1, '1, 3'd3, 16'h1234, 8'h08};
      vt[3]  = '{'0, 3'd0, 16'h0000, '0,   '1, '0, 3'd0, 16'h0000, 8'h00};
      vt[4]  = '{'1, 3'd0, 16'h00A0, '1,   '1, '0, 3'd0, 16'h0000, 8'h00};
      vt[5]  = '{'1, 3'd1, 16'h00A1, '1,   '1, '0, 3'd0, 16'h00A0, 8'h01};
      vt[6]  = '{'1, 3'd2, 16'h00A2, '1,   '1, '0, 3'd0, 16'h00A0, 8'h03};
      vt[7]  = '{'1, 3'd3, 16'h00A3, '1,   '1, '0, 3'd0, 16'h00A0, 8'h07};
      vt[8]  = '{'0, 3'd0, 16'h0000, '1,   '0, '0, 3'd0, 16'h00A0, 8'h0F};
      vt[9]  = '{'1, 3'd5, 16'h0055, '0,   '0, '1, 3'd0, 16'h00A0, 8'h0F};
      vt[10] = '{'0, 3'd0, 16'h0000, '0,   '1, '1, 3'd1, 16'h00A1, 8'h0E};
      vt[11] = '{'0, 3'd0, 16'h0000, '0,   '1, '1, 3'd2, 16'h00A2, 8'h0C};
      vt[12] = '{'0, 3'd0, 16'h0000, '0,   '1, '1, 3'd3, 16'h00A3, 8'h08};
      vt[13] = '{'0, 3'd0, 16'h0000, '0,   '1, '0, 3'd0, 16'h0000, 8'h00};
      vt[14] = '{'1, 3'd6, 16'h0606, '0,   '1, '0, 3'd0, 16'h0000, 8'h00};
      vt[15] = '{'1, 3'd7, 16'h0707, '0,   '1, '1, 3'd6, 16'h0606, 8'h40};
      vt[16] = '{'1, 3'd6, 16'h0B0B, '0,   '1, '1, 3'd7, 16'h0707, 8'h80};
      vt[17] = '{'0, 3'd0, 16'h0000, '0,   '1, '1, 3'd6, 16'h0B0B, 8'h40};
      vt[18] = '{'0, 3'd0, 16'h0000, '0,   '1, '0, 3'd0, 16'h0000, 8'h00};
      vt[19] = '{'1, 3'd2, 16'h0001, '1,   '1, '0, 3'd0, 16'h0000, 8'h00};
      vt[20] = '{'1, 3'd2, 16'h0002, '1,   '1, '0, 3'd2, 16'h0001, 8'h04};
      vt[21] = '{'0, 3'd0, 16'h0000, '0,   '1, '1, 3'd2, 16'h0001, 8'h04};
      vt[22] = '{'0, 3'd0, 16'h0000, '0,   '1, '1, 3'd2, 16'h0002, 8'h04};
      vt[23] = '{'0, 3'd0, 16'h0000, '0,   '1, '0, 3'd0, 16'h0000, 8'h00};

      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset fwd_hit1", 32'(fwd_hit1), 32'h0);
      chk("reset fwd_data1", 32'(fwd_data1), 32'h0);
      chk("reset err", 32'(err), 32'h0);
      @(negedge clk);

      for (int i = 0; i < 24; i++) begin
         drive(vt[i].v, vt[i].sel, vt[i].data, vt[i].stall);
         #1;
         chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vt[i].rdy));
         chk($sformatf("v%0d write_en", i), 32'(write_en), 32'(vt[i].we));
         chk($sformatf("v%0d write_sel", i), 32'(write_sel), 32'(vt[i].wsel));
         chk($sformatf("v%0d write_data", i), 32'(write_data), 32'(vt[i].wdata));
         chk($sformatf("v%0d pending", i), 32'(pending), 32'(vt[i].pend));
         chk($sformatf("v%0d err", i), 32'(err), 32'h0);
         @(negedge clk);
      end

      // forwarding picks the youngest of two r5 entries
      drive(1'b1, 3'd5, 16'h00AA, 1'b1);
      step();
      drive(1'b1, 3'd5, 16'h00BB, 1'b1);
      step();
      drive(1'b0, 3'd0, 16'h0000, 1'b1);
      rd1 = 3'd5;
      rd2 = 3'd6;
      #1;
      chk("fwd hit1", 32'(fwd_hit1), 32'(FWD));
      chk("fwd data1", 32'(fwd_data1), FWD ? 32'h00BB : 32'h0);
      chk("fwd hit2", 32'(fwd_hit2), 32'h0);
      chk("fwd data2", 32'(fwd_data2), 32'h0);
      chk("fwd pending", 32'(pending), 32'h20);
      chk("fwd write_data", 32'(write_data), 32'h00AA);

      // third entry, then reset discards everything
      drive(1'b1, 3'd1, 16'h0111, 1'b1);
      step();
      drive(1'b0, 3'd0, 16'h0000, 1'b1);
      #1;
      chk("pre-rst pending", 32'(pending), 32'h22);
      rst = 1'b1;
      drive(1'b1, 3'd4, 16'h0444, 1'b1);
      #1;
      chk("in-rst in_ready", 32'(in_ready), 32'h0);
      step();
      rst = 1'b0;
      drive(1'b0, 3'd0, 16'h0000, 1'b0);
      #1;
      chk("post-rst pending", 32'(pending), 32'h00);
      chk("post-rst in_ready", 32'(in_ready), 32'h1);
      chk("post-rst fwd_hit1", 32'(fwd_hit1), 32'h0);
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("post-rst write_en c%0d", c), 32'(write_en), 32'h0);
         step();
      end

      // request with unknown select flags err and must not be queued
      xsel = 3'bx;
      exp_err = $isunknown(xsel);
      drive(1'b1, xsel, 16'h0DEF, 1'b1);
      #1;
      chk("xsel err", 32'(err), 32'(exp_err));
      step();
      drive(1'b0, xsel, 16'h0000, 1'b1);
      #1;
      chk("xsel idle err", 32'(err), 32'h0);
      chk("xsel pending", 32'(pending), exp_err ? 32'h0 : 32'(8'h01 << xsel));

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end
endmodule
